// File: rtl/idu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idu_pkg
// Description : Shared types for the instruction decode unit. It holds the
//               predecoded opcode class enum, the RV32I major opcodes and the
//               instruction-buffer entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package idu_pkg;

  // Field widths of a stored buffer entry. The buffer's ILEN/PC_W parameters
  // must not exceed these. Narrower values are zero-extended into the entry.
  localparam int IDU_ILEN = 32;
  localparam int IDU_PC_W = 32;

  typedef enum logic [3:0] {
    OC_NONE    = 4'd0,
    OC_LUI     = 4'd1,
    OC_AUIPC   = 4'd2,
    OC_JAL     = 4'd3,
    OC_JALR    = 4'd4,
    OC_BRANCH  = 4'd5,
    OC_LOAD    = 4'd6,
    OC_STORE   = 4'd7,
    OC_OPIMM   = 4'd8,
    OC_OP      = 4'd9,
    OC_FENCE   = 4'd10,
    OC_SYSTEM  = 4'd11,
    OC_ILLEGAL = 4'd12
  } opclass_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [IDU_ILEN-1:0] instr;
    logic [IDU_PC_W-1:0] pc;
    opclass_e            opclass;
    logic                illegal;
  } ibuf_entry_t;

endpackage : idu_pkg
`default_nettype wire

// File: rtl/idu_predecode.sv
`default_nettype none
// ============================================================================
// Module      : idu_predecode
// Description : Purely combinational opcode classifier. It maps the major
//               opcode onto an opclass_e and flags encodings that are not
//               recognised.
// Ports       : opcode  in  7  instr[6:0]
//               opclass out 4  predecoded class
//               illegal out 1  unrecognised opcode or instr[1:0] != 2'b11
// Revision    : 1.0 - initial release
// ============================================================================
module idu_predecode
  import idu_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   opclass,
  output logic       illegal
);

  always_comb begin
    opclass = OC_ILLEGAL;
    case (opcode)
      OPC_LUI:    opclass = OC_LUI;
      OPC_AUIPC:  opclass = OC_AUIPC;
      OPC_JAL:    opclass = OC_JAL;
      OPC_JALR:   opclass = OC_JALR;
      OPC_BRANCH: opclass = OC_BRANCH;
      OPC_LOAD:   opclass = OC_LOAD;
      OPC_STORE:  opclass = OC_STORE;
      OPC_OPIMM:  opclass = OC_OPIMM;
      OPC_OP:     opclass = OC_OP;
      OPC_FENCE:  opclass = OC_FENCE;
      OPC_SYSTEM: opclass = OC_SYSTEM;
      default:    opclass = OC_ILLEGAL;
    endcase
    // Every recognised opcode already ends in 2'b11. The explicit length check
    // keeps compressed-looking words illegal if the table ever grows.
    illegal = (opclass == OC_ILLEGAL) || (opcode[1:0] != 2'b11);
  end

endmodule : idu_predecode
`default_nettype wire

// File: rtl/idu_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : idu_inst_buffer
// Description : DEPTH-entry first-word-fall-through queue of {instr, pc}
//               pairs between fetch and decode. Entries are predecoded at push
//               time, so the head outputs are driven straight from storage.
// Ports       : soc_clk, IBUF_reset        clock / sync active-high reset
//               fetch_valid/ready/instr/pc  fetch-side handshake and payload
//               IDU_stall, flush            pop blocker / redirect discard
//               dec_valid/ready/instr/pc    decode-side handshake and payload
//               dec_opclass, dec_illegal    predecode of the head entry
//               count, drop_err             occupancy / sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module idu_inst_buffer
  import idu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ILEN  = 32,
  parameter int PC_W  = 32
) (
  input  logic                       soc_clk,
  input  logic                       IBUF_reset,
  input  logic                       fetch_valid,
  input  logic [ILEN-1:0]            fetch_instr,
  input  logic [PC_W-1:0]            fetch_pc,
  output logic                       fetch_ready,
  input  logic                       IDU_stall,
  input  logic                       flush,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [ILEN-1:0]            dec_instr,
  output logic [PC_W-1:0]            dec_pc,
  output opclass_e                   dec_opclass,
  output logic                       dec_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             drop_err_q, drop_err_d;
  ibuf_entry_t      mem_q [DEPTH];
  ibuf_entry_t      mem_d [DEPTH];

  opclass_e         pd_opclass;
  logic             pd_illegal;
  ibuf_entry_t      wr_entry;
  ibuf_entry_t      head;
  logic             push;
  logic             pop;

  idu_predecode u_predecode (
    .opcode  (fetch_instr[6:0]),
    .opclass (pd_opclass),
    .illegal (pd_illegal)
  );

  // fetch_ready depends only on occupancy, so a full buffer refuses a push
  // even when a pop happens in the same cycle.
  assign fetch_ready = (count_q != CNT_W'(DEPTH));
  assign dec_valid   = (count_q != '0);
  assign count       = count_q;
  assign drop_err    = drop_err_q;

  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop  = dec_valid & dec_ready & ~IDU_stall & ~flush;

  always_comb begin
    wr_entry         = '0;
    wr_entry.instr   = IDU_ILEN'(fetch_instr);
    wr_entry.pc      = IDU_PC_W'(fetch_pc);
    wr_entry.opclass = pd_opclass;
    wr_entry.illegal = pd_illegal;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    // A push refused while full is recorded. A push lost to a flush is not.
    drop_err_d = drop_err_q | (fetch_valid & ~fetch_ready & ~flush);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge soc_clk) begin
    if (IBUF_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage contents are don't-care after reset. Validity comes from count_q.
  always_ff @(posedge soc_clk) begin
    mem_q <= mem_d;
  end

  // Head outputs fall through from storage. When the buffer is empty they are
  // forced to idle values so decode never sees stale data.
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    dec_instr   = '0;
    dec_pc      = '0;
    dec_opclass = OC_NONE;
    dec_illegal = 1'b0;
    if (dec_valid) begin
      dec_instr   = ILEN'(head.instr);
      dec_pc      = PC_W'(head.pc);
      dec_opclass = head.opclass;
      dec_illegal = head.illegal;
    end
  end

endmodule : idu_inst_buffer
`default_nettype wire

// File: tb/tb_idu_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_idu_inst_buffer
// Description : Directed scoreboard bench for idu_inst_buffer. Each step
//               drives one cycle of inputs and checks every output against the
//               expected-entry queue. Accepted pushes are then queued and
//               popped entries are removed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idu_inst_buffer;
  import idu_pkg::*;

  localparam int DEPTH = 4;

  logic        soc_clk = 1'b0;
  logic        IBUF_reset;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        IDU_stall;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  opclass_e    dec_opclass;
  logic        dec_illegal;
  logic [2:0]  count;
  logic        drop_err;

  always #5 soc_clk = ~soc_clk;

  idu_inst_buffer #(.DEPTH(DEPTH), .ILEN(32), .PC_W(32)) dut (
    .soc_clk     (soc_clk),
    .IBUF_reset  (IBUF_reset),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .IDU_stall   (IDU_stall),
    .flush       (flush),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_opclass (dec_opclass),
    .dec_illegal (dec_illegal),
    .count       (count),
    .drop_err    (drop_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  oc;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  logic m_drop;
  int   tests;
  int   fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("count",       64'(count),       64'(sb.size()));
    chk("fetch_ready", 64'(fetch_ready), 64'(sb.size() != DEPTH));
    chk("dec_valid",   64'(dec_valid),   64'(sb.size() != 0));
    chk("drop_err",    64'(drop_err),    64'(m_drop));
    if (sb.size() != 0) begin
      chk("dec_instr",   64'(dec_instr),   64'(sb[0].instr));
      chk("dec_pc",      64'(dec_pc),      64'(sb[0].pc));
      chk("dec_opclass", 64'(dec_opclass), 64'(sb[0].oc));
      chk("dec_illegal", 64'(dec_illegal), 64'(sb[0].ill));
    end else begin
      chk("empty_instr",   64'(dec_instr),   64'h0);
      chk("empty_pc",      64'(dec_pc),      64'h0);
      chk("empty_opclass", 64'(dec_opclass), 64'(OC_NONE));
      chk("empty_illegal", 64'(dec_illegal), 64'h0);
    end
  endtask

  // One clock of stimulus. Outputs are checked just before the edge.
  task automatic step(input bit fv, input logic [31:0] instr, input logic [31:0] pc,
                      input opclass_e oc, input bit ill,
                      input bit rdy, input bit stall, input bit fl);
    bit   do_push;
    bit   do_pop;
    exp_t e;
    fetch_valid = fv;
    fetch_instr = instr;
    fetch_pc    = pc;
    dec_ready   = rdy;
    IDU_stall   = stall;
    flush       = fl;
    #1;
    check_outputs();
    do_push = fv && (sb.size() != DEPTH) && !fl;
    do_pop  = (sb.size() != 0) && rdy && !stall && !fl;
    if (fv && (sb.size() == DEPTH) && !fl) m_drop = 1'b1;
    e.instr = instr;
    e.pc    = pc;
    e.oc    = oc;
    e.ill   = ill;
    @(posedge soc_clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(e);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input opclass_e oc, input bit ill, input bit rdy);
    step(1'b1, instr, pc, oc, ill, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 32'h0, OC_NONE, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  // Reset is applied with fetch and decode both active, so it must override them.
  task automatic do_reset();
    IBUF_reset  = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = 32'h0000_0013;
    fetch_pc    = 32'hDEAD_0000;
    dec_ready   = 1'b1;
    IDU_stall   = 1'b0;
    flush       = 1'b0;
    @(posedge soc_clk);
    #1;
    IBUF_reset  = 1'b0;
    fetch_valid = 1'b0;
    sb.delete();
    m_drop = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_drop = 1'b0;
    @(posedge soc_clk);
    #1;
    do_reset();

    // Single ADDI, then pop, then empty again
    push(32'h0050_0093, 32'h0, OC_OPIMM, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to DEPTH, overflow attempt, drain in order
    push(32'h0000_00B7, 32'h0, OC_LUI,    1'b0, 1'b0);
    push(32'h0000_0097, 32'h4, OC_AUIPC,  1'b0, 1'b0);
    push(32'h0000_006F, 32'h8, OC_JAL,    1'b0, 1'b0);
    push(32'h0000_0063, 32'hC, OC_BRANCH, 1'b0, 1'b0);
    push(32'h0000_0023, 32'h10, OC_STORE, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Steady occupancy of 2 with push+pop each cycle across pointer wrap
    push(32'h0000_0033, 32'h100, OC_OP, 1'b0, 1'b0);
    push(32'h0000_0033, 32'h104, OC_OP, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      push(32'h0000_0003, 32'h108 + 32'(4*i), OC_LOAD, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Stall holds the head while pushes continue
    push(32'h0000_0067, 32'h200, OC_JALR, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h0000_000F, 32'h204 + 32'(4*i), OC_FENCE, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset in the middle of traffic clears the queue and drop_err
    push(32'h0000_0013, 32'h300, OC_OPIMM, 1'b0, 1'b0);
    push(32'h0000_0013, 32'h304, OC_OPIMM, 1'b0, 1'b0);
    push(32'h0000_0013, 32'h308, OC_OPIMM, 1'b0, 1'b0);
    push(32'h0000_0013, 32'h30C, OC_OPIMM, 1'b0, 1'b0);
    push(32'h0000_0013, 32'h310, OC_OPIMM, 1'b0, 1'b0);
    idle(1'b0);
    do_reset();
    idle(1'b0);

    // Flush with 3 queued and a concurrent push
    push(32'h0000_0013, 32'h400, OC_OPIMM, 1'b0, 1'b0);
    push(32'h0000_0013, 32'h404, OC_OPIMM, 1'b0, 1'b0);
    push(32'h0000_0013, 32'h408, OC_OPIMM, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00B7, 32'h40C, OC_LUI, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Flush while full with fetch_valid high must not set drop_err
    for (int i = 0; i < 4; i++)
      push(32'h0000_0073, 32'h500 + 32'(4*i), OC_SYSTEM, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 32'h510, OC_OPIMM, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // Illegal encodings and SYSTEM, streamed
    push(32'h0000_0000, 32'h600, OC_ILLEGAL, 1'b1, 1'b1);
    push(32'h0000_007F, 32'h604, OC_ILLEGAL, 1'b1, 1'b1);
    push(32'h0000_0073, 32'h608, OC_SYSTEM,  1'b0, 1'b1);
    push(32'h0000_0010, 32'h60C, OC_ILLEGAL, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_idu_inst_buffer
`default_nettype wire
